// File: rtl/umi_req_arbiter_pkg.sv
// Shared UMI field widths, end-of-message bit position and arbiter state encoding.
// Imported by the arbiter top level and its pick sub-module.
package umi_req_arbiter_pkg;

  localparam int unsigned UMI_CW     = 32;
  localparam int unsigned UMI_AW     = 64;
  localparam int unsigned UMI_DW     = 128;
  localparam int unsigned UMI_EOMBIT = 22;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/umi_arb_pick.sv
// Combinational winner pick: rotate the request vector by the pointer, take the lowest set bit,
// then rotate the one-hot result back. Fixed priority simply uses a zero rotation.
module umi_arb_pick
  import umi_req_arbiter_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          mode,
  output logic [N-1:0]  win
);

  logic [PW-1:0]  w_base;
  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_first;
  logic [2*N-1:0] w_back;

  always_comb begin
    w_base  = mode ? '0 : ptr;
    w_dbl   = {req, req} >> w_base;
    w_rot   = w_dbl[N-1:0];
    // Isolate the lowest set bit of the rotated vector.
    w_first = w_rot & (~w_rot + N'(1));
    w_back  = {w_first, w_first} << w_base;
    win     = w_back[2*N-1:N];
  end

endmodule

// File: rtl/umi_req_arbiter.sv
// Message-aware N:1 UMI request arbiter. The owner keeps the output until it transfers an EOM beat,
// then re-arbitration happens at that same edge so back-to-back messages need no dead cycle.
module umi_req_arbiter
  import umi_req_arbiter_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned CW     = UMI_CW,
  parameter int unsigned AW     = UMI_AW,
  parameter int unsigned DW     = UMI_DW,
  parameter int unsigned EOMBIT = UMI_EOMBIT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mode,
  input  logic [N-1:0]    mask,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dstaddr,
  input  logic [N*AW-1:0] umi_in_srcaddr,
  input  logic [N*DW-1:0] umi_in_data,
  output logic [N-1:0]    umi_in_ready,
  output logic            umi_out_valid,
  output logic [CW-1:0]   umi_out_cmd,
  output logic [AW-1:0]   umi_out_dstaddr,
  output logic [AW-1:0]   umi_out_srcaddr,
  output logic [DW-1:0]   umi_out_data,
  input  logic            umi_out_ready,
  output logic [N-1:0]    grant,
  output logic            busy
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [0:0]    r_state;
  logic [PW-1:0] r_own;
  logic [PW-1:0] r_ptr;

  logic [N-1:0]  w_elig;
  logic [N-1:0]  w_win;
  logic [PW-1:0] w_win_idx;
  logic [PW-1:0] w_own_inc;
  logic [PW-1:0] w_pick_ptr;
  logic          w_busy;
  logic          w_gate;
  logic          w_own_valid;
  logic [CW-1:0] w_cmd;
  logic [AW-1:0] w_dst;
  logic [AW-1:0] w_src;
  logic [DW-1:0] w_data;
  logic          w_xfer;
  logic          w_eom_xfer;

  assign w_elig    = umi_in_valid & ~mask;
  assign w_busy    = (r_state == ST_BUSY);
  // No beat is offered or accepted during the reset cycle.
  assign w_gate    = w_busy & ~reset;
  assign w_own_inc = (r_own == PW'(N - 1)) ? '0 : r_own + PW'(1);

  always_comb begin
    w_own_valid = 1'b0;
    w_cmd       = '0;
    w_dst       = '0;
    w_src       = '0;
    w_data      = '0;
    for (int i = 0; i < N; i++) begin
      if (r_own == PW'(i)) begin
        w_own_valid = umi_in_valid[i];
        w_cmd       = umi_in_cmd[i*CW +: CW];
        w_dst       = umi_in_dstaddr[i*AW +: AW];
        w_src       = umi_in_srcaddr[i*AW +: AW];
        w_data      = umi_in_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    umi_in_ready = '0;
    grant        = '0;
    for (int i = 0; i < N; i++) begin
      if (r_own == PW'(i)) begin
        umi_in_ready[i] = w_gate & umi_out_ready;
        grant[i]        = w_busy;
      end
    end
  end

  assign busy            = w_busy;
  assign umi_out_valid   = w_gate & w_own_valid;
  assign umi_out_cmd     = w_busy ? w_cmd  : '0;
  assign umi_out_dstaddr = w_busy ? w_dst  : '0;
  assign umi_out_srcaddr = w_busy ? w_src  : '0;
  assign umi_out_data    = w_busy ? w_data : '0;

  assign w_xfer     = umi_out_valid & umi_out_ready;
  assign w_eom_xfer = w_xfer & w_cmd[EOMBIT];
  // On an EOM beat the advanced pointer is already used for this edge's pick.
  assign w_pick_ptr = w_eom_xfer ? w_own_inc : r_ptr;

  umi_arb_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req  (w_elig),
    .ptr  (w_pick_ptr),
    .mode (mode),
    .win  (w_win)
  );

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (w_win[i]) w_win_idx = PW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_own   <= '0;
      r_ptr   <= '0;
    end else if (!w_busy) begin
      if (|w_elig) begin
        r_state <= ST_BUSY;
        r_own   <= w_win_idx;
      end
    end else if (w_eom_xfer) begin
      r_ptr <= w_own_inc;
      if (|w_elig) begin
        r_own <= w_win_idx;
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_umi_req_arbiter.sv
// Randomized bench: a driver feeds message sources and a queue-based reference model;
// a monitor pops one expected record per cycle and compares against the arbiter outputs.
module tb_umi_req_arbiter;
  import umi_req_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int CW  = UMI_CW;
  localparam int AW  = UMI_AW;
  localparam int DW  = UMI_DW;
  localparam int EOM = UMI_EOMBIT;
  localparam int FW  = CW + 2 * AW + DW;

  logic            clk;
  logic            reset;
  logic            mode;
  logic [N-1:0]    mask;
  logic [N-1:0]    umi_in_valid;
  logic [N*CW-1:0] umi_in_cmd;
  logic [N*AW-1:0] umi_in_dstaddr;
  logic [N*AW-1:0] umi_in_srcaddr;
  logic [N*DW-1:0] umi_in_data;
  logic [N-1:0]    umi_in_ready;
  logic            umi_out_valid;
  logic [CW-1:0]   umi_out_cmd;
  logic [AW-1:0]   umi_out_dstaddr;
  logic [AW-1:0]   umi_out_srcaddr;
  logic [DW-1:0]   umi_out_data;
  logic            umi_out_ready;
  logic [N-1:0]    grant;
  logic            busy;

  umi_req_arbiter #(
    .N      (N),
    .CW     (CW),
    .AW     (AW),
    .DW     (DW),
    .EOMBIT (EOM)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .mode            (mode),
    .mask            (mask),
    .umi_in_valid    (umi_in_valid),
    .umi_in_cmd      (umi_in_cmd),
    .umi_in_dstaddr  (umi_in_dstaddr),
    .umi_in_srcaddr  (umi_in_srcaddr),
    .umi_in_data     (umi_in_data),
    .umi_in_ready    (umi_in_ready),
    .umi_out_valid   (umi_out_valid),
    .umi_out_cmd     (umi_out_cmd),
    .umi_out_dstaddr (umi_out_dstaddr),
    .umi_out_srcaddr (umi_out_srcaddr),
    .umi_out_data    (umi_out_data),
    .umi_out_ready   (umi_out_ready),
    .grant           (grant),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            busy;
    logic [N-1:0]  grant;
    logic [N-1:0]  rdy;
    bit            ov;
    logic [FW-1:0] fields;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Message sources: each holds its current beat until the arbiter accepts it.
  int            len  [N];
  int            beat [N];
  int            msgno[N];
  logic [CW-1:0] s_cmd[N];
  logic [AW-1:0] s_dst[N];
  logic [AW-1:0] s_src[N];
  logic [DW-1:0] s_dat[N];

  // Reference model state.
  bit m_busy;
  int m_own;
  int m_ptr;

  task automatic new_beat(input int i);
    s_cmd[i]      = $urandom;
    s_cmd[i][EOM] = (beat[i] == len[i] - 1);
    s_dst[i]      = {$urandom, $urandom};
    s_src[i]      = {$urandom, $urandom};
    s_dat[i]      = {$urandom, $urandom, 8'(i), 8'(msgno[i]), 16'(beat[i])};
  endtask

  task automatic new_msg(input int i);
    len[i]   = $urandom_range(1, 5);
    beat[i]  = 0;
    msgno[i] = msgno[i] + 1;
    new_beat(i);
  endtask

  function automatic int pick(input logic [N-1:0] e, input int p, input bit md);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = md ? k : (p + k) % N;
      if (e[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: sampled just before the rising edge, well after inputs settle.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("busy", FW'(busy), FW'(e.busy));
        check("grant", FW'(grant), FW'(e.grant));
        check("in_ready", FW'(umi_in_ready), FW'(e.rdy));
        check("out_valid", FW'(umi_out_valid), FW'(e.ov));
        check("out_fields", {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data},
              e.fields);
      end
    end
  end

  // Phase table: valid %, mask %, ready %, mode.
  int ph_pv[6] = '{100, 100, 70, 50, 90, 30};
  int ph_pm[6] = '{0, 0, 20, 50, 10, 0};
  int ph_pr[6] = '{100, 100, 60, 50, 80, 100};
  bit ph_md[6] = '{0, 1, 0, 1, 0, 0};

  initial begin
    reset = 1'b1;
    mode = 1'b0;
    mask = '0;
    umi_in_valid = '0;
    umi_in_cmd = '0;
    umi_in_dstaddr = '0;
    umi_in_srcaddr = '0;
    umi_in_data = '0;
    umi_out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      msgno[i] = 0;
      new_msg(i);
    end
    m_busy = 0;
    m_own  = 0;
    m_ptr  = 0;
    repeat (2) @(posedge clk);

    for (int ph = 0; ph < 6; ph++) begin
      for (int cyc = 0; cyc < 300; cyc++) begin
        exp_t          e;
        logic [N-1:0]  elig;
        bit            r;
        bit            xfer;
        bit            eom;
        int            p;

        @(negedge clk);
        r = (cyc < 2) || ($urandom_range(0, 99) == 0);
        reset = r;
        mode = ph_md[ph];
        umi_out_ready = ($urandom_range(0, 99) < ph_pr[ph]);
        for (int i = 0; i < N; i++) begin
          umi_in_valid[i] = ($urandom_range(0, 99) < ph_pv[ph]);
          mask[i] = ($urandom_range(0, 99) < ph_pm[ph]);
          umi_in_cmd[i*CW +: CW] = s_cmd[i];
          umi_in_dstaddr[i*AW +: AW] = s_dst[i];
          umi_in_srcaddr[i*AW +: AW] = s_src[i];
          umi_in_data[i*DW +: DW] = s_dat[i];
        end
        elig = umi_in_valid & ~mask;

        e.busy  = m_busy;
        e.grant = '0;
        e.rdy   = '0;
        e.ov    = 0;
        e.fields = '0;
        if (m_busy) begin
          e.grant[m_own] = 1'b1;
          e.fields = {s_cmd[m_own], s_dst[m_own], s_src[m_own], s_dat[m_own]};
          if (!r) begin
            e.ov = umi_in_valid[m_own];
            e.rdy[m_own] = umi_out_ready;
          end
        end
        sb.push_back(e);

        xfer = e.ov && umi_out_ready;
        eom  = xfer && s_cmd[m_own][EOM];
        if (xfer) begin
          beat[m_own]++;
          if (beat[m_own] == len[m_own]) new_msg(m_own);
          else new_beat(m_own);
        end

        if (r) begin
          m_busy = 0;
          m_own  = 0;
          m_ptr  = 0;
          for (int i = 0; i < N; i++) new_msg(i);
        end else if (!m_busy) begin
          p = pick(elig, m_ptr, mode);
          if (p >= 0) begin
            m_busy = 1;
            m_own  = p;
          end
        end else if (eom) begin
          m_ptr = (m_own + 1) % N;
          p = pick(elig, m_ptr, mode);
          if (p >= 0) m_own = p;
          else m_busy = 0;
        end
      end
    end

    @(negedge clk);
    #6;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d records left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/umi_req_arbiter.md
# umi_req_arbiter

Message-aware arbiter that shares one UMI request port between N UMI hosts, typically in front of a `umi_fifo_flex` / `umi_mem_agent` chain. Arbitration happens only at UMI message boundaries. Once a requester wins, it owns the output until it transfers a beat with EOM set, so multi-beat messages are never interleaved. Round-robin or fixed-priority policy is selectable at run time, and each requester can be masked.

## Interface
Parameters:
- `N`, 4, number of requesters (2..16)
- `CW`, 32, UMI command width
- `AW`, 64, UMI address width
- `DW`, 128, UMI data width
- `EOMBIT`, 22, bit of cmd carrying end-of-message

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `mode`  in  1  0 = round-robin, 1 = fixed priority (index 0 highest)
- `mask`  in  N  1 = requester excluded from new arbitration
- `umi_in_valid`  in  N  per-requester valid
- `umi_in_cmd`  in  N*CW  requester i at `[i*CW +: CW]`
- `umi_in_dstaddr`  in  N*AW  packed as cmd
- `umi_in_srcaddr`  in  N*AW  packed as cmd
- `umi_in_data`  in  N*DW  packed as cmd
- `umi_in_ready`  out  N  per-requester ready
- `umi_out_valid`  out  1  shared output valid
- `umi_out_cmd` / `umi_out_dstaddr` / `umi_out_srcaddr` / `umi_out_data`  out  CW/AW/AW/DW  owner's fields
- `umi_out_ready`  in  1  downstream ready
- `grant`  out  N  one-hot owner; zero when IDLE
- `busy`  out  1  1 in BUSY state

## Operation
- Eligible set: `umi_in_valid & ~mask`.
- States:
  - IDLE: no owner; `umi_out_valid` = 0; all `umi_in_ready` = 0.
  - BUSY: owner register `own` is valid.
- IDLE -> BUSY: when the eligible set is nonzero, the winner is loaded into `own` at the clock edge.
- In BUSY:
  - `umi_out_*` = requester `own` fields.
  - `umi_out_valid` = `umi_in_valid[own]`.
  - `umi_in_ready[own]` = `umi_out_ready`; every other ready = 0.
  - Mask changes are ignored for the current owner until the message ends.
- Beat transfer: `umi_out_valid & umi_out_ready`.
- On a transfer with `cmd[EOMBIT]` = 1:
  - The round-robin pointer is set to `own+1` (mod N).
  - Re-arbitration runs over the eligible set at that same edge, including the old owner. For round-robin, the pointer value `own+1` is used.
  - If a winner exists, `own` loads the winner and the state stays BUSY (no dead cycle).
  - Otherwise the state goes to IDLE.
- Winner selection:
  - mode=1: lowest eligible index.
  - mode=0: first eligible index at or after the pointer, with wrap-around.
- Pointer reset value is 0. The pointer only advances on an EOM transfer.
- Owner drops valid mid-message: stay BUSY and wait. No timeout.
- Masking the owner mid-message has no effect until EOM.
- Data is passed through with no buffering and no field modification.

## Timing
- Reset (synchronous, at the edge with `reset`=1):
  - State = IDLE, `own` = 0, pointer = 0.
  - Outputs: `grant` = 0, `busy` = 0, `umi_out_valid` = 0, `umi_in_ready` = 0, `umi_out_*` fields = 0.
  - Reset mid-message abandons the message. No output beat is produced on the reset cycle.
- Latency:
  - From IDLE: 1 cycle from first eligible valid to `umi_out_valid`.
  - While BUSY: 0 cycles; valid and ready are combinational pass-through.
- Back-to-back single-beat messages from different requesters sustain 1 beat/cycle.
- `umi_in_ready` never depends on `umi_in_valid` of the same requester.
- Fairness (round-robin): any continuously eligible requester is granted within N messages.

## Structure
- EOM bit position and the UMI field widths belong in the shared UMI package (`umi_messages.vh`). The arbiter takes `EOMBIT` from it by default.
- One sub-module, `umi_arb_pick`: combinational inputs `req[N]`, `ptr`, `mode`; output one-hot `win[N]`, implemented as double-width rotate plus priority encode.
- The top level holds the IDLE/BUSY register, `own`, the pointer and the output mux.

## Test plan
- Single requester, N=4, req1 sends a 3-beat message (EOM on beat 3), ready=1 → grant=0010 from cycle 1; 3 consecutive output beats; IDLE after; pointer=2.
- All 4 valid, single-beat EOM messages, mode=0, ready=1 → grant order 0,1,2,3,0,… at 1 beat/cycle.
- Same stimulus, mode=1 → requester 0 wins every cycle while valid; 1–3 starve until req0 drops.
- req2 mid-message (beat 2 of 4), req0 becomes valid, `mask[2]` set → req2 finishes all 4 beats, then req0 is granted; no interleaving.
- `umi_out_ready` toggles 1/0 randomly during a 5-beat message → data order preserved; `umi_in_ready[own]` mirrors ready; other readies stay 0.
- `reset` asserted on beat 2 of a message → next cycle: `busy`=0, `grant`=0, `umi_out_valid`=0; pointer=0; fresh arbitration after reset deasserts.
